// File: rtl/ecdsa_lh_wb_if.sv
// ecdsa_lh_wb_if: header/hash stream from the logic-hash stage, verdict
// strobe from the ECDSA core and the write-back port into the logic-hash
// tables. The slave modport is the write-back block; the master modport is
// whatever drives the stream and consumes the write-back.
interface ecdsa_lh_wb_if #(
  parameter int FID_NBITS        = 12,
  parameter int LOGIC_HASH_NBITS = 256,
  parameter int SERIAL_NUM_NBITS = 32,
  parameter int PPL_NBITS        = 8,
  parameter int DATA_NBITS       = 128
);
  logic                        lh_ecdsa_valid;
  logic                        lh_ecdsa_sop;
  logic                        lh_ecdsa_eop;
  logic [DATA_NBITS-1:0]       lh_ecdsa_hdr_data;
  logic [FID_NBITS-1:0]        lh_ecdsa_fid;
  logic                        lh_ecdsa_hash_valid;
  logic [LOGIC_HASH_NBITS-1:0] lh_ecdsa_hash_data;
  logic                        ecdsa_lh_ready;
  logic                        ecdsa_verify_valid;
  logic                        ecdsa_verify_pass;
  logic                        ecdsa_lh_wr;
  logic [FID_NBITS-1:0]        ecdsa_lh_waddr;
  logic [LOGIC_HASH_NBITS-1:0] ecdsa_lh_wdata;
  logic [SERIAL_NUM_NBITS-1:0] ecdsa_lh_sn_wdata;
  logic [PPL_NBITS-1:0]        ecdsa_lh_ppl_wdata;

  modport master (
    output lh_ecdsa_valid, lh_ecdsa_sop, lh_ecdsa_eop, lh_ecdsa_hdr_data,
           lh_ecdsa_fid, lh_ecdsa_hash_valid, lh_ecdsa_hash_data,
           ecdsa_verify_valid, ecdsa_verify_pass,
    input  ecdsa_lh_ready, ecdsa_lh_wr, ecdsa_lh_waddr, ecdsa_lh_wdata,
           ecdsa_lh_sn_wdata, ecdsa_lh_ppl_wdata
  );

  modport slave (
    input  lh_ecdsa_valid, lh_ecdsa_sop, lh_ecdsa_eop, lh_ecdsa_hdr_data,
           lh_ecdsa_fid, lh_ecdsa_hash_valid, lh_ecdsa_hash_data,
           ecdsa_verify_valid, ecdsa_verify_pass,
    output ecdsa_lh_ready, ecdsa_lh_wr, ecdsa_lh_waddr, ecdsa_lh_wdata,
           ecdsa_lh_sn_wdata, ecdsa_lh_ppl_wdata
  );
endinterface

// File: rtl/ecdsa_lh_wb.sv
// ecdsa_lh_wb: captures {fid, hash, sn, ppl} from each type1 header packet,
// queues it in a small context FIFO, pairs it with the in-order ECDSA verdict
// and writes passing contexts back into the logic-hash tables.
// Optional build macro: ECDSA_LH_WB_STATS_EN (saturating pass/fail/orphan
// counters; without it the stat outputs are tied to zero).
//
// state  | meaning
// IDLE   | waiting for an SOP beat
// IN_PKT | SOP captured, waiting for the EOP beat to commit the context
module ecdsa_lh_wb #(
  parameter int FID_NBITS        = 12,
  parameter int LOGIC_HASH_NBITS = 256,
  parameter int SERIAL_NUM_NBITS = 32,
  parameter int PPL_NBITS        = 8,
  parameter int DATA_NBITS       = 128,
  parameter int SN_POS           = 95,
  parameter int PPL_POS          = 63,
  parameter int CTX_DEPTH        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  ecdsa_lh_wb_if.slave      lh,
  output logic              framing_err,
  output logic              overflow_err,
  output logic [15:0]       stat_pass_cnt,
  output logic [15:0]       stat_fail_cnt,
  output logic [15:0]       stat_orphan_cnt
);

  // CTX_DEPTH is a power of two >= 2, so pointers wrap by plain overflow.
  localparam int PTR_NBITS   = $clog2(CTX_DEPTH);
  localparam int CNT_NBITS   = $clog2(CTX_DEPTH) + 1;
  localparam int ENTRY_NBITS = FID_NBITS + LOGIC_HASH_NBITS + SERIAL_NUM_NBITS + PPL_NBITS;
  localparam logic [CNT_NBITS-1:0] DEPTH_C   = CNT_NBITS'(CTX_DEPTH);
  localparam logic [CNT_NBITS-1:0] READY_LIM = CNT_NBITS'(CTX_DEPTH - 1);

  typedef enum logic {IDLE, IN_PKT} state_e;

  state_e                      state_q, state_d;
  logic [FID_NBITS-1:0]        ctx_fid_q, ctx_fid_d;
  logic [LOGIC_HASH_NBITS-1:0] ctx_hash_q, ctx_hash_d;
  logic [SERIAL_NUM_NBITS-1:0] ctx_sn_q, ctx_sn_d;
  logic [PPL_NBITS-1:0]        ctx_ppl_q, ctx_ppl_d;

  logic [ENTRY_NBITS-1:0]      fifo_mem_q [CTX_DEPTH];
  logic [ENTRY_NBITS-1:0]      fifo_mem_d [CTX_DEPTH];
  logic [PTR_NBITS-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_NBITS-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_NBITS-1:0]        count_q, count_d;

  logic                        ready_q, ready_d;
  logic                        wr_q, wr_d;
  logic [FID_NBITS-1:0]        waddr_q, waddr_d;
  logic [LOGIC_HASH_NBITS-1:0] wdata_q, wdata_d;
  logic [SERIAL_NUM_NBITS-1:0] sn_q, sn_d;
  logic [PPL_NBITS-1:0]        ppl_q, ppl_d;
  logic                        framing_q, framing_d;
  logic                        overflow_q, overflow_d;

  logic [FID_NBITS-1:0]        cap_fid;
  logic [LOGIC_HASH_NBITS-1:0] cap_hash;
  logic [SERIAL_NUM_NBITS-1:0] cap_sn;
  logic [PPL_NBITS-1:0]        cap_ppl;
  logic                        commit;
  logic [ENTRY_NBITS-1:0]      commit_entry;
  logic [ENTRY_NBITS-1:0]      head_entry;
  logic                        push;
  logic                        pop;
  logic                        unused_hdr_bits;

  // A hash only belongs to this packet when it arrives with the SOP beat;
  // capture is only ever taken on SOP, so the strobe alone decides pairing.
  assign cap_fid  = lh.lh_ecdsa_fid;
  assign cap_hash = lh.lh_ecdsa_hash_valid ? lh.lh_ecdsa_hash_data : '0;
  assign cap_sn   = lh.lh_ecdsa_hdr_data[SN_POS -: SERIAL_NUM_NBITS];
  assign cap_ppl  = lh.lh_ecdsa_hdr_data[PPL_POS -: PPL_NBITS];
  assign unused_hdr_bits = ^lh.lh_ecdsa_hdr_data;

  // Capture FSM: latch context on SOP, commit on EOP, flag broken framing.
  always_comb begin
    state_d      = state_q;
    ctx_fid_d    = ctx_fid_q;
    ctx_hash_d   = ctx_hash_q;
    ctx_sn_d     = ctx_sn_q;
    ctx_ppl_d    = ctx_ppl_q;
    commit       = 1'b0;
    commit_entry = {ctx_fid_q, ctx_hash_q, ctx_sn_q, ctx_ppl_q};
    framing_d    = 1'b0;
    if (lh.lh_ecdsa_valid) begin
      if (lh.lh_ecdsa_sop) begin
        // An SOP inside a packet abandons the held context and restarts.
        framing_d  = (state_q == IN_PKT);
        ctx_fid_d  = cap_fid;
        ctx_hash_d = cap_hash;
        ctx_sn_d   = cap_sn;
        ctx_ppl_d  = cap_ppl;
        if (lh.lh_ecdsa_eop) begin
          commit       = 1'b1;
          commit_entry = {cap_fid, cap_hash, cap_sn, cap_ppl};
          state_d      = IDLE;
        end else begin
          state_d = IN_PKT;
        end
      end else if (state_q == IDLE) begin
        framing_d = 1'b1;
      end else if (lh.lh_ecdsa_eop) begin
        commit  = 1'b1;
        state_d = IDLE;
      end
    end
  end

  // A full FIFO still accepts a commit when the head leaves in the same cycle.
  assign head_entry = fifo_mem_q[rd_ptr_q];
  assign pop        = lh.ecdsa_verify_valid && (count_q != '0);
  assign push       = commit && ((count_q != DEPTH_C) || pop);

  // Context FIFO bookkeeping, overflow flag and registered ready.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = commit_entry;
      wr_ptr_d             = wr_ptr_q + PTR_NBITS'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_NBITS'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_NBITS'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_NBITS'(1);
    end
    if (commit && !push) begin
      overflow_d = 1'b1;
    end
    // One slot stays spare for a packet whose SOP is already in flight.
    ready_d = (count_d < READY_LIM);
  end

  // Write-back port: one-cycle strobe, data held between strobes.
  always_comb begin
    wr_d    = pop && lh.ecdsa_verify_pass;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    sn_d    = sn_q;
    ppl_d   = ppl_q;
    if (wr_d) begin
      {waddr_d, wdata_d, sn_d, ppl_d} = head_entry;
    end
  end

  // State, context, FIFO and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ctx_fid_q  <= '0;
      ctx_hash_q <= '0;
      ctx_sn_q   <= '0;
      ctx_ppl_q  <= '0;
      for (int i = 0; i < CTX_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b0;
      wr_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      sn_q       <= '0;
      ppl_q      <= '0;
      framing_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctx_fid_q  <= ctx_fid_d;
      ctx_hash_q <= ctx_hash_d;
      ctx_sn_q   <= ctx_sn_d;
      ctx_ppl_q  <= ctx_ppl_d;
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      wr_q       <= wr_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      sn_q       <= sn_d;
      ppl_q      <= ppl_d;
      framing_q  <= framing_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef ECDSA_LH_WB_STATS_EN
  logic [15:0] pass_cnt_q, pass_cnt_d;
  logic [15:0] fail_cnt_q, fail_cnt_d;
  logic [15:0] orphan_cnt_q, orphan_cnt_d;

  // Saturating statistics, updated on the verdict cycle.
  always_comb begin
    pass_cnt_d   = pass_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    orphan_cnt_d = orphan_cnt_q;
    if (pop && lh.ecdsa_verify_pass && (pass_cnt_q != 16'hFFFF)) begin
      pass_cnt_d = pass_cnt_q + 16'd1;
    end
    if (pop && !lh.ecdsa_verify_pass && (fail_cnt_q != 16'hFFFF)) begin
      fail_cnt_d = fail_cnt_q + 16'd1;
    end
    if (lh.ecdsa_verify_valid && !pop && (orphan_cnt_q != 16'hFFFF)) begin
      orphan_cnt_d = orphan_cnt_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      orphan_cnt_q <= '0;
    end else begin
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      orphan_cnt_q <= orphan_cnt_d;
    end
  end

  assign stat_pass_cnt   = pass_cnt_q;
  assign stat_fail_cnt   = fail_cnt_q;
  assign stat_orphan_cnt = orphan_cnt_q;
`else
  assign stat_pass_cnt   = 16'h0;
  assign stat_fail_cnt   = 16'h0;
  assign stat_orphan_cnt = 16'h0;
`endif

  assign lh.ecdsa_lh_ready     = ready_q;
  assign lh.ecdsa_lh_wr        = wr_q;
  assign lh.ecdsa_lh_waddr     = waddr_q;
  assign lh.ecdsa_lh_wdata     = wdata_q;
  assign lh.ecdsa_lh_sn_wdata  = sn_q;
  assign lh.ecdsa_lh_ppl_wdata = ppl_q;
  assign framing_err           = framing_q;
  assign overflow_err          = overflow_q;

endmodule

// File: tb/tb_ecdsa_lh_wb.sv
// tb_ecdsa_lh_wb: vector table plus hand-written sequences; a context model
// and an expected-write scoreboard check every write-back and its timing.
module tb_ecdsa_lh_wb;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        framing_err, overflow_err;
  logic [15:0] stat_pass_cnt, stat_fail_cnt, stat_orphan_cnt;

  always #5 clk = ~clk;

  ecdsa_lh_wb_if #(.FID_NBITS(12), .LOGIC_HASH_NBITS(256), .SERIAL_NUM_NBITS(32),
                   .PPL_NBITS(8), .DATA_NBITS(128)) lh_if ();

  ecdsa_lh_wb #(.FID_NBITS(12), .LOGIC_HASH_NBITS(256), .SERIAL_NUM_NBITS(32),
                .PPL_NBITS(8), .DATA_NBITS(128), .SN_POS(95), .PPL_POS(63),
                .CTX_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .lh              (lh_if),
    .framing_err     (framing_err),
    .overflow_err    (overflow_err),
    .stat_pass_cnt   (stat_pass_cnt),
    .stat_fail_cnt   (stat_fail_cnt),
    .stat_orphan_cnt (stat_orphan_cnt)
  );

  typedef struct {
    logic [11:0]  fid;
    logic [255:0] hash;
    logic [31:0]  sn;
    logic [7:0]   ppl;
  } ctx_t;

  typedef struct {
    ctx_t c;
    int   due;
  } exp_t;

  typedef struct {
    logic [11:0]  fid;
    logic [255:0] hash;
    logic [31:0]  sn;
    logic [7:0]   ppl;
    int           nbeats;
    logic         hv;
    logic         pass;
    int           exp_wr;
  } vec_t;

  ctx_t mq[$];
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vt[6];

  int   n_tests = 0, n_fail = 0;
  int   cyc = 0;
  int   wr_seen = 0, fe_seen = 0;
  int   m_pass = 0, m_fail = 0, m_orph = 0, m_fe = 0;
  logic m_ovf = 1'b0;
  logic [11:0]  hold_addr = '0;
  logic [255:0] hold_data = '0;
  logic [31:0]  hold_sn = '0;
  logic [7:0]   hold_ppl = '0;

  localparam logic [255:0] H1 = {4{64'h0123_4567_89AB_CDEF}};
  localparam logic [255:0] H2 = {8{32'hC0DE_F00D}};
  localparam logic [255:0] H3 = {16{16'h5A3C}};
  localparam logic [255:0] H4 = {32{8'h81}};

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write is matched in order against the expected queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_addr = '0; hold_data = '0; hold_sn = '0; hold_ppl = '0;
    end else begin
      if (framing_err) fe_seen++;
      if (lh_if.ecdsa_lh_wr) begin
        wr_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_wr", 256'(lh_if.ecdsa_lh_wr), 256'(0));
        end else begin
          mon_e = exp_q.pop_front();
          chk("wb_cycle", 256'(cyc), 256'(mon_e.due));
          chk("wb_addr", 256'(lh_if.ecdsa_lh_waddr), 256'(mon_e.c.fid));
          chk("wb_hash", lh_if.ecdsa_lh_wdata, mon_e.c.hash);
          chk("wb_sn", 256'(lh_if.ecdsa_lh_sn_wdata), 256'(mon_e.c.sn));
          chk("wb_ppl", 256'(lh_if.ecdsa_lh_ppl_wdata), 256'(mon_e.c.ppl));
          hold_addr = mon_e.c.fid; hold_data = mon_e.c.hash;
          hold_sn = mon_e.c.sn; hold_ppl = mon_e.c.ppl;
        end
      end else begin
        chk("hold_addr", 256'(lh_if.ecdsa_lh_waddr), 256'(hold_addr));
        chk("hold_data", lh_if.ecdsa_lh_wdata, hold_data);
        chk("hold_sn_ppl", 256'({lh_if.ecdsa_lh_sn_wdata, lh_if.ecdsa_lh_ppl_wdata}),
            256'({hold_sn, hold_ppl}));
        if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
          mon_e = exp_q.pop_front();
          chk("wb_missing", 256'(lh_if.ecdsa_lh_wr), 256'(1));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    lh_if.lh_ecdsa_valid = 1'b0; lh_if.lh_ecdsa_sop = 1'b0; lh_if.lh_ecdsa_eop = 1'b0;
    lh_if.lh_ecdsa_hdr_data = '0; lh_if.lh_ecdsa_fid = '0;
    lh_if.lh_ecdsa_hash_valid = 1'b0; lh_if.lh_ecdsa_hash_data = '0;
    lh_if.ecdsa_verify_valid = 1'b0; lh_if.ecdsa_verify_pass = 1'b0;
  endtask

  function automatic logic [127:0] mk_hdr(input logic [31:0] sn, input logic [7:0] ppl);
    logic [127:0] h;
    h = {4{32'hA5A5_5A5A}};
    h[95:64] = sn;
    h[63:56] = ppl;
    return h;
  endfunction

  task automatic set_beat(input logic sop, input logic eop, input logic [11:0] fid,
                          input logic [127:0] hdr, input logic hv, input logic [255:0] h);
    lh_if.lh_ecdsa_valid = 1'b1; lh_if.lh_ecdsa_sop = sop; lh_if.lh_ecdsa_eop = eop;
    lh_if.lh_ecdsa_fid = fid; lh_if.lh_ecdsa_hdr_data = hdr;
    lh_if.lh_ecdsa_hash_valid = hv; lh_if.lh_ecdsa_hash_data = h;
  endtask

  task automatic beat(input logic sop, input logic eop, input logic [11:0] fid,
                      input logic [127:0] hdr, input logic hv, input logic [255:0] h);
    set_beat(sop, eop, fid, hdr, hv, h);
    tick();
    drive_idle();
  endtask

  task automatic model_commit(input ctx_t c);
    if (mq.size() < DEPTH) mq.push_back(c);
    else m_ovf = 1'b1;
  endtask

  // Body beats carry a decoy fid, header and hash strobe that must be ignored.
  task automatic send_pkt(input logic [11:0] fid, input logic [255:0] h, input logic [31:0] sn,
                          input logic [7:0] ppl, input int nbeats, input logic hv);
    ctx_t c;
    c.fid = fid; c.hash = hv ? h : '0; c.sn = sn; c.ppl = ppl;
    beat(1'b1, nbeats == 1, fid, mk_hdr(sn, ppl), hv, h);
    for (int i = 1; i < nbeats; i++)
      beat(1'b0, i == nbeats - 1, ~fid, ~mk_hdr(sn, ppl), 1'b1, ~h);
    model_commit(c);
  endtask

  task automatic verdict(input logic pass);
    exp_t e;
    lh_if.ecdsa_verify_valid = 1'b1;
    lh_if.ecdsa_verify_pass = pass;
    if (mq.size() == 0) m_orph++;
    else begin
      e.c = mq.pop_front();
      e.due = cyc + 1;
      if (pass) begin exp_q.push_back(e); m_pass++; end
      else m_fail++;
    end
    tick();
    lh_if.ecdsa_verify_valid = 1'b0;
    lh_if.ecdsa_verify_pass = 1'b0;
  endtask

  task automatic chk_ready(input string name);
    chk(name, 256'(lh_if.ecdsa_lh_ready), 256'(mq.size() < DEPTH - 1));
  endtask

  task automatic chk_stats(input string name);
`ifdef ECDSA_LH_WB_STATS_EN
    chk({name, "_pass"}, 256'(stat_pass_cnt), 256'(m_pass));
    chk({name, "_fail"}, 256'(stat_fail_cnt), 256'(m_fail));
    chk({name, "_orph"}, 256'(stat_orphan_cnt), 256'(m_orph));
`else
    chk({name, "_stats_off"}, 256'({stat_pass_cnt, stat_fail_cnt, stat_orphan_cnt}), 256'(0));
`endif
  endtask

  int w0;
  ctx_t cb;
  exp_t eb;

  initial begin
    vt[0] = '{12'h05A, H1, 32'h0000_0010, 8'h03, 3, 1'b1, 1'b1, 1};
    vt[1] = '{12'h001, H2, 32'h0000_0020, 8'h07, 1, 1'b1, 1'b0, 0};
    vt[2] = '{12'hFFF, H3, 32'hFFFF_FFFF, 8'hFF, 2, 1'b1, 1'b1, 1};
    vt[3] = '{12'h000, H4, 32'h0000_0000, 8'h00, 1, 1'b0, 1'b1, 1};
    vt[4] = '{12'h123, ~H1, 32'h8000_0001, 8'h80, 5, 1'b1, 1'b1, 1};
    vt[5] = '{12'h456, ~H3, 32'h1234_5678, 8'h11, 2, 1'b1, 1'b0, 0};

    drive_idle();
    tick(); tick(); tick();
    chk("rst_ready", 256'(lh_if.ecdsa_lh_ready), 256'(0));
    chk("rst_wr", 256'(lh_if.ecdsa_lh_wr), 256'(0));
    chk("rst_errs", 256'({framing_err, overflow_err}), 256'(0));
    chk_stats("rst");
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 256'(lh_if.ecdsa_lh_ready), 256'(0));
    tick();
    chk("ready_after_release", 256'(lh_if.ecdsa_lh_ready), 256'(1));

    // Table-driven single packets, each followed by its verdict.
    foreach (vt[i]) begin
      w0 = wr_seen;
      send_pkt(vt[i].fid, vt[i].hash, vt[i].sn, vt[i].ppl, vt[i].nbeats, vt[i].hv);
      chk_ready("vec_ready");
      verdict(vt[i].pass);
      tick(); tick();
      chk("vec_wr_count", 256'(wr_seen - w0), 256'(vt[i].exp_wr));
      chk_stats("vec");
    end

    // Orphan verdict with nothing queued.
    w0 = wr_seen;
    verdict(1'b1);
    tick(); tick();
    chk("orphan_no_wr", 256'(wr_seen - w0), 256'(0));
    chk_stats("orphan");

    // Fill the FIFO, overflow it, then drain with back-to-back verdicts.
    w0 = wr_seen;
    for (int i = 0; i < DEPTH; i++) begin
      send_pkt(12'h100 + 12'(i), H1 ^ 256'(i), 32'h100 + 32'(i), 8'(i), 1, 1'b1);
      chk_ready("fill_ready");
    end
    chk("ovf_before", 256'(overflow_err), 256'(0));
    send_pkt(12'h1FF, H2, 32'h1FF, 8'h1F, 1, 1'b1);
    chk("ovf_after", 256'(overflow_err), 256'(m_ovf));
    for (int i = 0; i < DEPTH; i++) verdict(1'b1);
    tick(); tick();
    chk("drain_wr_count", 256'(wr_seen - w0), 256'(DEPTH));
    chk_ready("drain_ready");
    chk("ovf_sticky", 256'(overflow_err), 256'(1));
    chk_stats("drain");

    // Framing: SOP inside a packet, then stray beats outside any packet.
    beat(1'b1, 1'b0, 12'h007, mk_hdr(32'h77, 8'h77), 1'b1, H3);
    beat(1'b0, 1'b0, 12'h000, '0, 1'b0, '0);
    beat(1'b1, 1'b0, 12'h002, mk_hdr(32'h22, 8'h22), 1'b1, H4);
    beat(1'b0, 1'b1, 12'h000, '0, 1'b0, '0);
    m_fe++;
    cb = '{12'h002, H4, 32'h22, 8'h22};
    model_commit(cb);
    tick(); tick();
    chk("framing_once", 256'(fe_seen), 256'(m_fe));
    chk_ready("framing_ready");
    beat(1'b0, 1'b0, 12'h003, '0, 1'b0, '0);
    beat(1'b0, 1'b1, 12'h004, '0, 1'b0, '0);
    m_fe += 2;
    tick(); tick();
    chk("framing_stray", 256'(fe_seen), 256'(m_fe));
    chk_ready("stray_no_commit");
    verdict(1'b1);
    tick();

    // A hash strobe without a type1 SOP is not paired with the next packet.
    lh_if.lh_ecdsa_hash_valid = 1'b1;
    lh_if.lh_ecdsa_hash_data = ~H2;
    tick();
    drive_idle();
    send_pkt(12'h0AB, H2, 32'hAB, 8'h0A, 2, 1'b1);
    verdict(1'b1);
    tick();

    // Commit and pop in the same cycle leave the occupancy unchanged.
    send_pkt(12'h0C1, H3, 32'hC1, 8'h01, 1, 1'b1);
    cb = '{12'h0C2, H4, 32'hC2, 8'h02};
    set_beat(1'b1, 1'b1, cb.fid, mk_hdr(cb.sn, cb.ppl), 1'b1, cb.hash);
    lh_if.ecdsa_verify_valid = 1'b1;
    lh_if.ecdsa_verify_pass = 1'b1;
    eb.c = mq.pop_front();
    eb.due = cyc + 1;
    exp_q.push_back(eb);
    m_pass++;
    model_commit(cb);
    tick();
    drive_idle();
    chk_ready("simul_ready");
    verdict(1'b1);
    tick(); tick();
    chk("simul_drained", 256'(exp_q.size()), 256'(0));
    chk_stats("simul");

    // Reset with two contexts queued flushes everything.
    send_pkt(12'h0E1, H1, 32'hE1, 8'hE1, 1, 1'b1);
    send_pkt(12'h0E2, H2, 32'hE2, 8'hE2, 2, 1'b1);
    send_pkt(12'h0E3, H3, 32'hE3, 8'hE3, 1, 1'b1);
    send_pkt(12'h0E4, H4, 32'hE4, 8'hE4, 1, 1'b1);
    send_pkt(12'h0E5, H4, 32'hE5, 8'hE5, 1, 1'b1);
    chk("pre_rst_ovf", 256'(overflow_err), 256'(1));
    verdict(1'b0); verdict(1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready_wr", 256'({lh_if.ecdsa_lh_ready, lh_if.ecdsa_lh_wr}), 256'(0));
    chk("mid_rst_waddr", 256'(lh_if.ecdsa_lh_waddr), 256'(0));
    chk("mid_rst_wdata", lh_if.ecdsa_lh_wdata, '0);
    chk("mid_rst_sn_ppl", 256'({lh_if.ecdsa_lh_sn_wdata, lh_if.ecdsa_lh_ppl_wdata}), 256'(0));
    chk("mid_rst_errs", 256'({framing_err, overflow_err}), 256'(0));
    mq.delete();
    exp_q.delete();
    m_pass = 0; m_fail = 0; m_orph = 0; m_ovf = 1'b0;
    chk_stats("mid_rst");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 256'(lh_if.ecdsa_lh_ready), 256'(1));
    w0 = wr_seen;
    verdict(1'b1);
    tick(); tick();
    chk("post_rst_no_wr", 256'(wr_seen - w0), 256'(0));
    chk_stats("post_rst");

    for (int i = 0; i < 5; i++) tick();
    chk("final_drain", 256'(exp_q.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
